// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one UART transmitter among four requesters
module uart_tx_sched #(
  parameter int BPS_DIV       = 5208,
  parameter int GAP_TICKS     = 2,
  parameter int TIMEOUT_TICKS = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  output logic        clk_bps,
  input  logic        tx_done,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        tx_err
);

  localparam int DW = $clog2(BPS_DIV);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BPS_DIV - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t        state;
  logic [DW-1:0] div;
  logic [TW-1:0] ticks;
  logic [DW-1:0] div_nxt;
  logic [1:0]    sel;
  logic [1:0]    idx;
  logic          found;

  assign div_nxt = (div == DIV_LAST) ? '0 : div + 1'b1;

  // Rotating priority: search upward from the requester after the last grant.
  always_comb begin
    sel   = grant_id;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = grant_id + 2'(k);
      if (!found && req_valid[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= '0;
      tx_data   <= 8'h00;
      tx_en     <= 1'b0;
      clk_bps   <= 1'b0;
      busy      <= 1'b0;
      grant_id  <= 2'd3;
      tx_err    <= 1'b0;
      div       <= '0;
      ticks     <= '0;
    end else begin
      req_ready <= '0;
      tx_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            req_ready <= 4'(1) << sel;
            tx_data   <= req_data[{sel, 3'b000} +: 8];
            grant_id  <= sel;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          div     <= '0;
          ticks   <= '0;
          clk_bps <= 1'b0;
          tx_en   <= 1'b1;
          state   <= SEND;
        end
        SEND: begin
          // tx_done takes precedence over a coincident timeout tick.
          if (tx_done || (clk_bps && ticks == TO_LAST)) begin
            tx_err  <= !tx_done;
            tx_en   <= 1'b0;
            div     <= '0;
            ticks   <= '0;
            clk_bps <= 1'b0;
            state   <= GAP;
          end else begin
            div     <= div_nxt;
            clk_bps <= (div_nxt == DIV_LAST);
            if (clk_bps) ticks <= ticks + 1'b1;
          end
        end
        GAP: begin
          if (clk_bps && ticks == GAP_LAST) begin
            busy    <= 1'b0;
            div     <= '0;
            ticks   <= '0;
            clk_bps <= 1'b0;
            state   <= IDLE;
          end else begin
            div     <= div_nxt;
            clk_bps <= (div_nxt == DIV_LAST);
            if (clk_bps) ticks <= ticks + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
